// File: rtl/timer_pkg.sv
// Shared widths, prescaler select encodings and status/enable bit positions for the 8-bit timer.
package timer_pkg;

    localparam int unsigned TIMER_CNT_W = 8;
    localparam int unsigned TIMER_PSC_W = 4;

    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;

    localparam int unsigned TSR_OVF_BIT  = 0;
    localparam int unsigned TSR_UDF_BIT  = 1;
    localparam int unsigned TSR_CMP_BIT  = 2;
    localparam int unsigned TIER_OVF_BIT = 0;
    localparam int unsigned TIER_UDF_BIT = 1;
    localparam int unsigned TIER_CMP_BIT = 2;

    // Clock divide ratio selected by a TCR clock-select field.
    function automatic int unsigned psc_div(input logic [1:0] cks);
        return 32'd2 << cks;
    endfunction

endpackage

// File: rtl/timer_cnt_core_if.sv
// Decoded register-block fields into the counting core and count/status back out.
interface timer_cnt_core_if #(
    parameter int unsigned CNT_W = timer_pkg::TIMER_CNT_W
);
    logic             tcr_load;
    logic             tcr_updown;
    logic             tcr_en;
    logic [1:0]       tcr_cks;
    logic [CNT_W-1:0] tdr;
    logic [CNT_W-1:0] tcmp;
    logic             ovf_clr;
    logic             udf_clr;
    logic             cmp_clr;
    logic             ovf_ie;
    logic             udf_ie;
    logic             cmp_ie;
    logic [CNT_W-1:0] tcnt;
    logic             ovf_flag;
    logic             udf_flag;
    logic             cmp_flag;
    logic             irq;

    modport master (
        output tcr_load, tcr_updown, tcr_en, tcr_cks, tdr, tcmp,
        output ovf_clr, udf_clr, cmp_clr, ovf_ie, udf_ie, cmp_ie,
        input  tcnt, ovf_flag, udf_flag, cmp_flag, irq
    );

    modport slave (
        input  tcr_load, tcr_updown, tcr_en, tcr_cks, tdr, tcmp,
        input  ovf_clr, udf_clr, cmp_clr, ovf_ie, udf_ie, cmp_ie,
        output tcnt, ovf_flag, udf_flag, cmp_flag, irq
    );
endinterface

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts enabled cycles and emits a one-cycle tick every 2^(cks+1) clocks.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PSC_W = TIMER_PSC_W
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [1:0] cks_i,
    output logic       tick_c_o
);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_lim;
    logic [1:0]       cks_q;
    logic             restart;

    // A select change restarts the period so the new divide ratio applies from a clean phase.
    always_comb begin
        psc_d    = psc_q + PSC_W'(1);
        tick_c_o = 1'b0;
        psc_lim  = PSC_W'(psc_div(cks_i) - 32'd1);
        restart  = !en_i || load_i || (cks_i != cks_q);
        if (restart) begin
            psc_d = '0;
        end else if (psc_q == psc_lim) begin
            tick_c_o = 1'b1;
            psc_d    = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            psc_q <= '0;
            cks_q <= CKS_DIV2;
        end else begin
            psc_q <= psc_d;
            cks_q <= cks_i;
        end
    end

endmodule

// File: rtl/timer_cnt_core.sv
// 8-bit timer counting engine: up/down counter, sticky wrap flags and interrupt request.
// Optional compare flag is built when TIMER_CMP_EN is defined.
module timer_cnt_core
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = TIMER_CNT_W,
    parameter int unsigned PSC_W = TIMER_PSC_W
) (
    input logic              pclk,
    input logic              preset,
    timer_cnt_core_if.slave  bus
);

    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] tcnt_step;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             tick;
    logic             wrap_up;
    logic             wrap_dn;

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_psc (
        .pclk     (pclk),
        .preset   (preset),
        .en_i     (bus.tcr_en),
        .load_i   (bus.tcr_load),
        .cks_i    (bus.tcr_cks),
        .tick_c_o (tick)
    );

    // Prescaler never ticks while loading, so load needs no extra gating of the flags.
    always_comb begin
        tcnt_step = bus.tcr_updown ? (tcnt_q - CNT_W'(1)) : (tcnt_q + CNT_W'(1));
        wrap_up   = tick && !bus.tcr_updown && (tcnt_q == '1);
        wrap_dn   = tick &&  bus.tcr_updown && (tcnt_q == '0);
        tcnt_d    = tcnt_q;
        if (bus.tcr_load) begin
            tcnt_d = bus.tdr;
        end else if (tick) begin
            tcnt_d = tcnt_step;
        end
        ovf_d = wrap_up || (ovf_q && !bus.ovf_clr);
        udf_d = wrap_dn || (udf_q && !bus.udf_clr);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            tcnt_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

`ifdef TIMER_CMP_EN
    logic cmp_q, cmp_d;

    always_comb begin
        cmp_d = (tick && (tcnt_step == bus.tcmp)) || (cmp_q && !bus.cmp_clr);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    assign bus.cmp_flag = cmp_q;
    assign bus.irq      = (ovf_q && bus.ovf_ie) || (udf_q && bus.udf_ie) || (cmp_q && bus.cmp_ie);
`else
    logic unused_cmp;
    assign unused_cmp   = ^{bus.tcmp, bus.cmp_clr, bus.cmp_ie};
    assign bus.cmp_flag = 1'b0;
    assign bus.irq      = (ovf_q && bus.ovf_ie) || (udf_q && bus.udf_ie);
`endif

    assign bus.tcnt     = tcnt_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.udf_flag = udf_q;

endmodule

// File: tb/tb_timer_cnt_core.sv
// Bench for timer_cnt_core: directed scenarios plus random traffic against a cycle-level reference model.
module tb_timer_cnt_core;

    logic pclk = 1'b0;
    logic preset;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_cnt;
    int   m_elapsed;
    int   m_cks;
    bit   m_ovf, m_udf, m_cmp;

    timer_cnt_core_if #(.CNT_W(8)) bus ();

    timer_cnt_core dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.slave)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs presented to that edge.
    task automatic model_edge();
        bit tick;
        int nxt;
        bit set_o, set_u, set_c;
        tick  = 1'b0;
        set_o = 1'b0;
        set_u = 1'b0;
        set_c = 1'b0;
        if (preset) begin
            m_cnt = 0; m_elapsed = 0; m_cks = 0;
            m_ovf = 0; m_udf = 0; m_cmp = 0;
            return;
        end
        if (!bus.tcr_en || bus.tcr_load || int'(bus.tcr_cks) != m_cks) begin
            m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == (2 << bus.tcr_cks)) begin
                tick = 1'b1;
                m_elapsed = 0;
            end
        end
        nxt = m_cnt;
        if (bus.tcr_load) begin
            nxt = int'(bus.tdr);
        end else if (tick) begin
            if (bus.tcr_updown) begin
                nxt   = (m_cnt + 255) % 256;
                set_u = (m_cnt == 0);
            end else begin
                nxt   = (m_cnt + 1) % 256;
                set_o = (m_cnt == 255);
            end
            set_c = (nxt == int'(bus.tcmp));
        end
        m_cnt = nxt;
        m_ovf = set_o || (m_ovf && !bus.ovf_clr);
        m_udf = set_u || (m_udf && !bus.udf_clr);
`ifdef TIMER_CMP_EN
        m_cmp = set_c || (m_cmp && !bus.cmp_clr);
`else
        m_cmp = 1'b0;
`endif
        m_cks = int'(bus.tcr_cks);
    endtask

    function automatic bit model_irq();
        bit r;
        r = (m_ovf && bus.ovf_ie) || (m_udf && bus.udf_ie);
`ifdef TIMER_CMP_EN
        r = r || (m_cmp && bus.cmp_ie);
`endif
        return r;
    endfunction

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            model_edge();
            #1;
            chk("tcnt", 32'(bus.tcnt), 32'(m_cnt));
            chk("flags", 32'({bus.cmp_flag, bus.udf_flag, bus.ovf_flag}), 32'({m_cmp, m_udf, m_ovf}));
            chk("irq", 32'(bus.irq), 32'(model_irq()));
        end
    endtask

    initial begin
        preset         = 1'b1;
        bus.tcr_load   = 1'b0;
        bus.tcr_updown = 1'b0;
        bus.tcr_en     = 1'b0;
        bus.tcr_cks    = 2'b00;
        bus.tdr        = 8'h00;
        bus.tcmp       = 8'h10;
        bus.ovf_clr    = 1'b0;
        bus.udf_clr    = 1'b0;
        bus.cmp_clr    = 1'b0;
        bus.ovf_ie     = 1'b0;
        bus.udf_ie     = 1'b0;
        bus.cmp_ie     = 1'b0;
        #2;

        // Reset
        cyc(2);
        chk("rst_tcnt", 32'(bus.tcnt), 32'h00);
        chk("rst_flags", 32'({bus.cmp_flag, bus.udf_flag, bus.ovf_flag}), 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        preset = 1'b0;

        // Load holds the counter at TDR regardless of enable
        bus.tdr = 8'h5A; bus.tcr_load = 1'b1; bus.tcr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("load_hold", 32'(bus.tcnt), 32'h5A);
        end
        chk("load_flags", 32'({bus.udf_flag, bus.ovf_flag}), 32'h0);

        // Up count /2 through overflow
        bus.tdr = 8'hFE; cyc();
        bus.tcr_load = 1'b0; bus.tcr_updown = 1'b0; bus.tcr_cks = 2'b00; bus.ovf_ie = 1'b1;
        cyc(2);
        chk("up2_ff", 32'(bus.tcnt), 32'hFF);
        cyc(2);
        chk("up2_00", 32'(bus.tcnt), 32'h00);
        chk("up2_ovf", 32'(bus.ovf_flag), 32'h1);
        chk("up2_irq", 32'(bus.irq), 32'h1);

        // Clear coinciding with a fresh overflow: set wins; a lone clear then drops it
        bus.tdr = 8'hFF; bus.tcr_load = 1'b1; cyc();
        bus.tcr_load = 1'b0; cyc();
        bus.ovf_clr = 1'b1; cyc();
        chk("race_cnt", 32'(bus.tcnt), 32'h00);
        chk("race_ovf", 32'(bus.ovf_flag), 32'h1);
        cyc();
        bus.ovf_clr = 1'b0;
        chk("clr_ovf", 32'(bus.ovf_flag), 32'h0);
        chk("clr_irq", 32'(bus.irq), 32'h0);

        // Down count /16 through underflow, then a mid-period select change
        bus.tdr = 8'h01; bus.tcr_load = 1'b1; bus.tcr_updown = 1'b1; bus.tcr_cks = 2'b11;
        cyc();
        bus.tcr_load = 1'b0;
        cyc(15);
        chk("dn16_hold", 32'(bus.tcnt), 32'h01);
        cyc();
        chk("dn16_00", 32'(bus.tcnt), 32'h00);
        cyc(16);
        chk("dn16_ff", 32'(bus.tcnt), 32'hFF);
        chk("dn16_udf", 32'(bus.udf_flag), 32'h1);
        cyc(5);
        bus.tcr_cks = 2'b00;
        cyc(2);
        chk("cks_restart_hold", 32'(bus.tcnt), 32'hFF);
        cyc();
        chk("cks_restart_tick", 32'(bus.tcnt), 32'hFE);

        // Compare: count up from 0x0E toward TCMP=0x10
        bus.cmp_clr = 1'b1; bus.udf_clr = 1'b1;
        bus.tdr = 8'h0E; bus.tcr_load = 1'b1; bus.tcr_updown = 1'b0;
        cyc();
        bus.cmp_clr = 1'b0; bus.udf_clr = 1'b0; bus.tcr_load = 1'b0;
        cyc(2);
        chk("cmp_before", 32'(bus.cmp_flag), 32'h0);
        cyc(2);
        chk("cmp_tcnt", 32'(bus.tcnt), 32'h10);
`ifdef TIMER_CMP_EN
        chk("cmp_hit", 32'(bus.cmp_flag), 32'h1);
`else
        chk("cmp_tied", 32'(bus.cmp_flag), 32'h0);
`endif

        // Random traffic
        for (int it = 0; it < 3000; it++) begin
            preset = ($urandom_range(299) == 0);
            if ($urandom_range(15) == 0) bus.tcr_load = ~bus.tcr_load;
            if ($urandom_range(31) == 0) bus.tcr_en = ~bus.tcr_en;
            if ($urandom_range(39) == 0) bus.tcr_updown = ~bus.tcr_updown;
            if ($urandom_range(59) == 0) bus.tcr_cks = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) bus.tdr = 8'($urandom_range(255));
            if ($urandom_range(63) == 0) bus.tcmp = 8'($urandom_range(255));
            if ($urandom_range(31) == 0) begin
                bus.ovf_ie = 1'($urandom_range(1));
                bus.udf_ie = 1'($urandom_range(1));
                bus.cmp_ie = 1'($urandom_range(1));
            end
            bus.ovf_clr = ($urandom_range(19) == 0);
            bus.udf_clr = ($urandom_range(19) == 0);
            bus.cmp_clr = ($urandom_range(19) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
